// File: rtl/somador_pkg.sv
// Shared types and helpers for the serial adder/subtractor.
package somador_pkg;

    // Controller states.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Ceiling log2, used to size the chunk counter.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << r) < 64'(v)) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/somador_serial_if.sv
// Request/result bundle for the serial adder/subtractor.
interface somador_serial_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             overflow;

    modport master (
        output start, sub, a, b, cin,
        input  busy, done, s, cout, overflow
    );

    modport slave (
        input  start, sub, a, b, cin,
        output busy, done, s, cout, overflow
    );
endinterface

// File: rtl/somador_fatia.sv
// Combinational CHUNK-bit ripple-carry slice.
module somador_fatia #(
    parameter int unsigned CHUNK = 1
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             c_msb
);

    // Ripple the carry through the slice; c_msb is the carry into the top bit.
    always_comb begin : ripple
        logic [CHUNK:0] c;
        c     = '0;
        s     = '0;
        c[0]  = cin;
        for (int i = 0; i < int'(CHUNK); i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout  = c[CHUNK];
        c_msb = c[CHUNK-1];
    end

endmodule

// File: rtl/somador_serial.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands, CHUNK bits per clock, LSB first.
module somador_serial
    import somador_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CHUNK = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    somador_serial_if.slave  bus
);

    localparam int unsigned N     = WIDTH / CHUNK;
    localparam int unsigned CNT_W = (clog2(N) > 0) ? clog2(N) : 1;

    state_t             state;
    state_t             state_nx;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [WIDTH-1:0]   acc;
    logic               carry;
    logic [CNT_W-1:0]   cnt;

    logic [CHUNK-1:0]       sl_s;
    logic                   sl_cout;
    logic                   sl_cmsb;
    logic [WIDTH+CHUNK-1:0] acc_cat;
    logic [WIDTH-1:0]       acc_nx;

    logic capture_c;
    logic step_c;
    logic last_c;

    somador_fatia #(.CHUNK(CHUNK)) u_fatia (
        .a     (op_a[CHUNK-1:0]),
        .b     (op_b[CHUNK-1:0]),
        .cin   (carry),
        .s     (sl_s),
        .cout  (sl_cout),
        .c_msb (sl_cmsb)
    );

    // New slice sum enters at the top; after N steps the LSB chunk sits at bit 0.
    assign acc_cat = {sl_s, acc};
    assign acc_nx  = acc_cat[WIDTH+CHUNK-1:CHUNK];

    // State register; busy is registered alongside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            bus.busy <= 1'b0;
        end else begin
            state    <= state_nx;
            bus.busy <= (state_nx == ST_RUN);
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (bus.start) state_nx = ST_RUN;
            ST_RUN:  if (last_c)    state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Datapath control strobes.
    always_comb begin
        capture_c = 1'b0;
        step_c    = 1'b0;
        last_c    = 1'b0;
        case (state)
            ST_IDLE: capture_c = bus.start;
            ST_RUN: begin
                step_c = 1'b1;
                last_c = (cnt == CNT_W'(N - 1));
            end
            default: ;
        endcase
    end

    // Operand shift registers, carry, accumulator and chunk counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a  <= '0;
            op_b  <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else if (capture_c) begin
            op_a  <= bus.a;
            op_b  <= bus.sub ? ~bus.b : bus.b;
            carry <= bus.cin ^ bus.sub;
            cnt   <= '0;
        end else if (step_c) begin
            op_a  <= op_a >> CHUNK;
            op_b  <= op_b >> CHUNK;
            acc   <= acc_nx;
            carry <= sl_cout;
            cnt   <= cnt + CNT_W'(1);
        end
    end

    // Visible results only change on completion, never showing partial sums.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.done     <= 1'b0;
            bus.s        <= '0;
            bus.cout     <= 1'b0;
            bus.overflow <= 1'b0;
        end else begin
            bus.done <= last_c;
            if (last_c) begin
                bus.s        <= acc_nx;
                bus.cout     <= sl_cout;
                bus.overflow <= sl_cout ^ sl_cmsb;
            end
        end
    end

endmodule

// File: tb/tb_somador_serial.sv
// Directed bench for somador_serial with CHUNK=1 and CHUNK=4 instances.
module tb_somador_serial;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    somador_serial_if #(.WIDTH(8)) bus1 ();
    somador_serial_if #(.WIDTH(8)) bus4 ();

    somador_serial #(.WIDTH(8), .CHUNK(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    somador_serial #(.WIDTH(8), .CHUNK(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    task automatic drive1(input logic st, input logic sb, input logic [7:0] a,
                          input logic [7:0] b, input logic c);
        bus1.start = st; bus1.sub = sb; bus1.a = a; bus1.b = b; bus1.cin = c;
    endtask

    task automatic drive4(input logic st, input logic sb, input logic [7:0] a,
                          input logic [7:0] b, input logic c);
        bus4.start = st; bus4.sub = sb; bus4.a = a; bus4.b = b; bus4.cin = c;
    endtask

    // Step edges until done is seen (bounded); edges = 0 on timeout.
    task automatic wait_done1(output int edges, output int busy_cnt);
        int k;
        edges = 0; busy_cnt = 0; k = 0;
        while (edges == 0 && k < 40) begin
            @(posedge clk); #1;
            k++;
            if (bus1.busy) busy_cnt++;
            if (bus1.done) edges = k;
        end
    endtask

    task automatic wait_done4(output int edges, output int busy_cnt);
        int k;
        edges = 0; busy_cnt = 0; k = 0;
        while (edges == 0 && k < 40) begin
            @(posedge clk); #1;
            k++;
            if (bus4.busy) busy_cnt++;
            if (bus4.done) edges = k;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive1(0, 0, 8'h00, 8'h00, 0);
        drive4(0, 0, 8'h00, 8'h00, 0);
        #3;
        checks++;
        if ({bus1.busy, bus1.done, bus1.s, bus1.cout, bus1.overflow} !== 12'h000) begin
            errors++;
            $display("FAIL reset1: got busy=%b done=%b s=%h cout=%b ovf=%b, want all 0",
                     bus1.busy, bus1.done, bus1.s, bus1.cout, bus1.overflow);
        end
        checks++;
        if ({bus4.busy, bus4.done, bus4.s, bus4.cout, bus4.overflow} !== 12'h000) begin
            errors++;
            $display("FAIL reset4: got busy=%b done=%b s=%h cout=%b ovf=%b, want all 0",
                     bus4.busy, bus4.done, bus4.s, bus4.cout, bus4.overflow);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_add_basic();
        int e, bc;
        drive1(1, 0, 8'h5A, 8'h3C, 0);
        @(posedge clk); #1;
        bus1.start = 1'b0;
        checks++;
        if (bus1.busy !== 1'b1) begin
            errors++; $display("FAIL add_busy_accept: got %b want 1", bus1.busy);
        end
        wait_done1(e, bc);
        checks++;
        if (e !== 8) begin errors++; $display("FAIL add_latency: got %0d want 8", e); end
        checks++;
        if (bc !== 7) begin errors++; $display("FAIL add_busy_cycles: got %0d want 7 after accept", bc); end
        checks++;
        if (bus1.busy !== 1'b0) begin errors++; $display("FAIL add_busy_done: got %b want 0", bus1.busy); end
        checks++;
        if ({bus1.s, bus1.cout, bus1.overflow} !== {8'h96, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL add_5a_3c: got s=%h c=%b v=%b want s=96 c=0 v=1", bus1.s, bus1.cout, bus1.overflow);
        end
        @(posedge clk); #1;
        checks++;
        if (bus1.done !== 1'b0) begin errors++; $display("FAIL add_done_pulse: got %b want 0", bus1.done); end
    endtask

    task automatic test_add_wrap();
        int e, bc;
        drive1(1, 0, 8'hFF, 8'h01, 0);
        @(posedge clk); #1;
        bus1.start = 1'b0;
        wait_done1(e, bc);
        checks++;
        if ({bus1.s, bus1.cout, bus1.overflow} !== {8'h00, 1'b1, 1'b0} || e !== 8) begin
            errors++;
            $display("FAIL add_ff_01: got s=%h c=%b v=%b e=%0d want s=00 c=1 v=0 e=8",
                     bus1.s, bus1.cout, bus1.overflow, e);
        end
        drive1(1, 0, 8'h00, 8'h00, 1);
        @(posedge clk); #1;
        bus1.start = 1'b0;
        wait_done1(e, bc);
        checks++;
        if ({bus1.s, bus1.cout, bus1.overflow} !== {8'h01, 1'b0, 1'b0} || e !== 8) begin
            errors++;
            $display("FAIL add_cin: got s=%h c=%b v=%b e=%0d want s=01 c=0 v=0 e=8",
                     bus1.s, bus1.cout, bus1.overflow, e);
        end
    endtask

    task automatic test_sub_chunk4();
        int e, bc;
        drive4(1, 1, 8'h10, 8'h01, 0);
        @(posedge clk); #1;
        bus4.start = 1'b0;
        wait_done4(e, bc);
        checks++;
        if (e !== 2) begin errors++; $display("FAIL sub4_latency: got %0d want 2", e); end
        checks++;
        if ({bus4.s, bus4.cout, bus4.overflow} !== {8'h0F, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL sub4_10_01: got s=%h c=%b v=%b want s=0f c=1 v=0", bus4.s, bus4.cout, bus4.overflow);
        end
        drive4(1, 1, 8'h80, 8'h01, 0);
        @(posedge clk); #1;
        bus4.start = 1'b0;
        wait_done4(e, bc);
        checks++;
        if ({bus4.s, bus4.cout, bus4.overflow} !== {8'h7F, 1'b1, 1'b1} || e !== 2) begin
            errors++;
            $display("FAIL sub4_80_01: got s=%h c=%b v=%b e=%0d want s=7f c=1 v=1 e=2",
                     bus4.s, bus4.cout, bus4.overflow, e);
        end
    endtask

    task automatic test_start_ignored();
        int e, bc, dones;
        drive1(1, 0, 8'hC0, 8'h70, 0);
        @(posedge clk); #1;
        bus1.start = 1'b0;
        repeat (3) @(posedge clk);
        #1 drive1(1, 1, 8'hF0, 8'h0F, 1);
        @(posedge clk); #1;
        drive1(0, 0, 8'h00, 8'h00, 0);
        wait_done1(e, bc);
        checks++;
        if (e + 4 !== 8) begin errors++; $display("FAIL ign_latency: got %0d want 8", e + 4); end
        checks++;
        if ({bus1.s, bus1.cout, bus1.overflow} !== {8'h30, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL ign_result: got s=%h c=%b v=%b want s=30 c=1 v=0", bus1.s, bus1.cout, bus1.overflow);
        end
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (bus1.done) dones++;
        end
        checks++;
        if (dones !== 0) begin errors++; $display("FAIL ign_extra_done: got %0d want 0", dones); end
    endtask

    task automatic test_reset_midop();
        int e, bc, dones;
        drive1(1, 0, 8'h80, 8'h80, 1);
        @(posedge clk); #1;
        bus1.start = 1'b0;
        wait_done1(e, bc);
        checks++;
        if ({bus1.s, bus1.cout, bus1.overflow} !== {8'h01, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL rst_prior: got s=%h c=%b v=%b want s=01 c=1 v=1", bus1.s, bus1.cout, bus1.overflow);
        end
        drive1(1, 0, 8'h01, 8'h02, 0);
        @(posedge clk); #1;
        bus1.start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus1.busy, bus1.done, bus1.s, bus1.cout, bus1.overflow} !== 12'h000) begin
            errors++;
            $display("FAIL rst_async: got busy=%b done=%b s=%h c=%b v=%b want all 0",
                     bus1.busy, bus1.done, bus1.s, bus1.cout, bus1.overflow);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (bus1.done) dones++;
        end
        checks++;
        if (dones !== 0) begin errors++; $display("FAIL rst_no_done: got %0d want 0", dones); end
        drive1(1, 0, 8'h33, 8'h44, 0);
        @(posedge clk); #1;
        bus1.start = 1'b0;
        wait_done1(e, bc);
        checks++;
        if ({bus1.s, bus1.cout, bus1.overflow} !== {8'h77, 1'b0, 1'b0} || e !== 8) begin
            errors++;
            $display("FAIL rst_recover: got s=%h c=%b v=%b e=%0d want s=77 c=0 v=0 e=8",
                     bus1.s, bus1.cout, bus1.overflow, e);
        end
    endtask

    task automatic test_back_to_back();
        int e, bc;
        drive1(1, 0, 8'h5A, 8'h3C, 0);
        @(posedge clk); #1;
        wait_done1(e, bc);
        checks++;
        if ({bus1.s, bus1.cout, bus1.overflow} !== {8'h96, 1'b0, 1'b1} || e !== 8) begin
            errors++;
            $display("FAIL b2b_op1: got s=%h c=%b v=%b e=%0d want s=96 c=0 v=1 e=8",
                     bus1.s, bus1.cout, bus1.overflow, e);
        end
        drive1(1, 1, 8'h10, 8'h20, 0);
        wait_done1(e, bc);
        checks++;
        if ({bus1.s, bus1.cout, bus1.overflow} !== {8'hF0, 1'b0, 1'b0} || e !== 9) begin
            errors++;
            $display("FAIL b2b_op2: got s=%h c=%b v=%b e=%0d want s=f0 c=0 v=0 e=9",
                     bus1.s, bus1.cout, bus1.overflow, e);
        end
        drive1(1, 0, 8'h7F, 8'h7F, 1);
        wait_done1(e, bc);
        bus1.start = 1'b0;
        checks++;
        if ({bus1.s, bus1.cout, bus1.overflow} !== {8'hFF, 1'b0, 1'b1} || e !== 9) begin
            errors++;
            $display("FAIL b2b_op3: got s=%h c=%b v=%b e=%0d want s=ff c=0 v=1 e=9",
                     bus1.s, bus1.cout, bus1.overflow, e);
        end
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (bus1.busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: got busy=%b want 0", bus1.busy); end
    endtask

    initial begin
        test_reset();
        test_add_basic();
        test_add_wrap();
        test_sub_chunk4();
        test_start_ignored();
        test_reset_midop();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/somador_serial.md
# somador_serial

Parametrised multi-cycle adder/subtractor that processes a WIDTH-bit operand pair CHUNK bits per clock, LSB chunk first, using a single CHUNK-bit ripple slice. It generalises the team's combinational full-adder cell into a sequential datapath block with a start/busy/done handshake. It is used wherever area matters more than latency in the arithmetic examples.

## Interface

Parameters:
- WIDTH, default 8: operand/result width in bits; must be ≥ 2.
- CHUNK, default 1: bits processed per cycle; must divide WIDTH exactly.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- sub  in  1  0 = add, 1 = subtract; captured with start.
- a  in  WIDTH  operand A; captured with start.
- b  in  WIDTH  operand B; captured with start.
- cin  in  1  carry-in (add) or borrow-in (subtract); captured with start.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse: results updated.
- s  out  WIDTH  result.
- cout  out  1  carry-out; for subtract, 1 = no borrow.
- overflow  out  1  two's-complement signed overflow.

## Operation

- N = WIDTH/CHUNK chunk steps per operation.
- Arithmetic:
  - Add: s = a + b + cin.
  - Subtract: s = a + ~b + ~cin, i.e. a − b − cin.
  - Initial carry = cin XOR sub.
  - All arithmetic is modulo 2^WIDTH.
- overflow = (carry into bit WIDTH−1) XOR (carry out of bit WIDTH−1).
- State machine, two states:
  - IDLE: busy = 0. start = 1 at an edge captures a, (sub ? ~b : b), the initial carry, and sub. Chunk counter clears to 0; next state is RUN.
  - RUN: busy = 1. Each edge adds the current CHUNK-bit slice of A and B plus the carry register. It writes the slice sum into a shift/accumulate result register and updates the carry. The counter increments.
  - At the edge processing chunk N−1: s, cout and overflow load from the final values. done pulses, and the state returns to IDLE.
- Outputs s, cout and overflow hold their last completed result until the next completion. They never show partial sums.
- start while busy is ignored; no queueing, no error flag.
- Operand and control inputs are don't-care except at the accepting edge.

## Timing

- Reset (rst_n low, asynchronous): state = IDLE, busy = 0, done = 0, s = 0, cout = 0, overflow = 0. Internal registers and the counter clear.
- Deassertion is synchronised externally; the block assumes a clean release.
- Latency: start accepted at edge E0. Chunks are processed at edges E0+1 … E0+N. done = 1 and results are valid during the cycle after E0+N. done returns low at E0+N+1.
- busy is high from E0 up to E0+N, and low in the done cycle.
- Back-to-back: start high during the done cycle is accepted (state is IDLE). Throughput is one operation per N+1 cycles.
- Reset mid-operation aborts the operation immediately. No done pulse occurs, and the outputs go to their reset values.
- CHUNK = WIDTH is legal: N = 1, latency 1 edge after acceptance.

## Structure

- Shared package somador_pkg holds:
  - the state encodings ST_IDLE = 1'b0, ST_RUN = 1'b1;
  - the counter-width function clog2.
- Sub-module somador_fatia: purely combinational CHUNK-bit ripple adder.
  - Ports: a, b, cin, s, cout, plus c_msb (carry into the slice MSB), used for overflow on the last chunk.
- The top level contains only the FSM, counter, operand shift registers, carry register and result register.

## Test plan

- WIDTH=8, CHUNK=1, add 0x5A + 0x3C, cin=0 -> s=0x96, cout=0, overflow=1; done exactly 8 edges after acceptance; busy high for 8 cycles.
- WIDTH=8, CHUNK=1, add 0xFF + 0x01, cin=0 -> s=0x00, cout=1, overflow=0. Then add 0x00 + 0x00, cin=1 -> s=0x01.
- WIDTH=8, CHUNK=4, subtract 0x10 − 0x01, cin=0 -> s=0x0F, cout=1, overflow=0, done 2 edges after acceptance. Then subtract 0x80 − 0x01 -> s=0x7F, cout=1, overflow=1.
- start pulsed again 3 cycles into an operation (different operands) -> ignored; only one done; result matches the first operands.
- rst_n pulled low mid-operation, with results from a prior operation present -> all outputs 0 asynchronously; no done pulse; the next start completes normally.
- Back-to-back: start held high continuously for 3 operations -> 3 done pulses spaced N+1 cycles apart, each with correct results.
